// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shifter replacement: one bit position per clock, done pulses when out is ready.
// The operation-type port is named typ because "type" is a reserved word in SystemVerilog.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             typ,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [SHW-1:0] count;
  logic           dir_q, typ_q;
  logic           accept;
  logic           fill;

  // Requests are taken in IDLE and DONE alike so back-to-back ops need no bubble.
  assign accept = start && (state != SHIFT);
  assign fill   = typ_q ? out[WIDTH-1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (shamt != '0) ? SHIFT : DONE;
        else       state_nxt = IDLE;
      end
      SHIFT:   if (count == SHW'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      count <= '0;
      dir_q <= 1'b0;
      typ_q <= 1'b0;
    end else if (accept) begin
      out   <= a;
      count <= shamt;
      dir_q <= dir;
      typ_q <= typ;
    end else if (state == SHIFT) begin
      if (dir_q) out <= {fill, out[WIDTH-1:1]};
      else       out <= {out[WIDTH-2:0], 1'b0};
      count <= count - SHW'(1);
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: latency, shift results, start-while-busy, back-to-back and async reset.
module tb_iter_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        dir;
  logic        typ;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned stray;

  iter_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shamt (shamt),
    .dir   (dir),
    .typ   (typ),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, count busy cycles up to done, then check latency and result.
  // With disturb set, a spurious start and new pin values are driven mid-operation.
  task automatic run_op(input string tag, input logic [31:0] a_v, input logic [4:0] sh_v,
                        input logic dir_v, input logic typ_v, input logic [31:0] exp_out,
                        input int unsigned exp_busy, input logic disturb);
    int unsigned n;
    a = a_v; shamt = sh_v; dir = dir_v; typ = typ_v; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (disturb && n == 5) begin
        start = 1'b1; a = 32'h1; shamt = 5'd2; dir = 1'b0; typ = 1'b0;
      end
      if (disturb && n == 6) start = 1'b0;
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_done"}, {31'b0, done}, 32'h1);
    check({tag, "_out"}, out, exp_out);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; shamt = '0; dir = 1'b0; typ = 1'b0;
    #2;
    check("reset_out", out, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    #10 rst_n = 1'b1;
    step();

    // T1: left shift pushes the only set bit out
    run_op("t1_sll3", 32'h8000_0000, 5'd3, 1'b0, 1'b0, 32'h0000_0000, 3, 1'b0);
    step();
    check("t1_idle_busy", {31'b0, busy}, 32'h0);
    check("t1_idle_done", {31'b0, done}, 32'h0);

    // T2/T3: logical vs arithmetic right
    run_op("t2_srl1", 32'h8000_0000, 5'd1, 1'b1, 1'b0, 32'h4000_0000, 1, 1'b0);
    step();
    run_op("t3_sra1", 32'h8000_0000, 5'd1, 1'b1, 1'b1, 32'hC000_0000, 1, 1'b0);
    step();
    run_op("t3_sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 31, 1'b0);
    step();

    // Extra patterns: type ignored on left shift, logical right of a mid-word nibble
    run_op("sll_arith", 32'h8000_0001, 5'd1, 1'b0, 1'b1, 32'h0000_0002, 1, 1'b0);
    step();
    run_op("srl12", 32'h0000_F000, 5'd12, 1'b1, 1'b0, 32'h0000_000F, 12, 1'b0);
    step();

    // T4: zero shift amount
    run_op("t4_sh0", 32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h1234_5678, 0, 1'b0);
    step();
    a = 32'hA5A5_A5A5; shamt = 5'd7;
    step(); step();
    check("idle_hold_out", out, 32'h1234_5678);

    // T5: start ignored while shifting; back-to-back accept from DONE
    run_op("t5_ignore", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 31, 1'b1);
    step();
    run_op("t5_first", 32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 2, 1'b0);
    run_op("t5_b2b", 32'h0000_0001, 5'd4, 1'b0, 1'b0, 32'h0000_0010, 4, 1'b0);
    step();

    // T6: partial-cycle reset mid-shift
    a = 32'hDEAD_BEEF; shamt = 5'd20; dir = 1'b0; typ = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("t6_pre_busy", {31'b0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_out", out, 32'h0);
    check("t6_rst_busy", {31'b0, busy}, 32'h0);
    check("t6_rst_done", {31'b0, done}, 32'h0);
    #1 rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    check("t6_no_stray", stray, 32'h0);
    run_op("t6_fresh", 32'hF000_0000, 5'd4, 1'b1, 1'b1, 32'hFF00_0000, 4, 1'b0);
    step();
    check("t6_end_done", {31'b0, done}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
